// File: rtl/regfile_pkg.sv
// Shared types and sizes for the integer register-file write-back path.
package regfile_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of write-back requests; pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  wb_req_t       push_data,
  input  logic          pop,
  output wb_req_t       head,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count
);

  wb_req_t     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is not reset; an entry is only ever read after it was written.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-side controller for the 32x64 register file: ALU/load arbitration,
// load-return queue and outstanding-load scoreboard. Optional WB_BYPASS_EN.
module regfile_wb_ctrl
  import regfile_pkg::*;
#(
  parameter int LQ_DEPTH = 4,
  parameter int PEND_W   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alu_valid,
  input  logic [REG_ADDR_W-1:0]     alu_rd,
  input  logic [XLEN-1:0]           alu_data,
  input  logic                      mem_valid,
  output logic                      mem_ready,
  input  logic [REG_ADDR_W-1:0]     mem_rd,
  input  logic [XLEN-1:0]           mem_data,
  input  logic                      issue_load_valid,
  input  logic [REG_ADDR_W-1:0]     issue_load_rd,
  output logic                      issue_load_ready,
  input  logic [REG_ADDR_W-1:0]     rs1,
  input  logic [REG_ADDR_W-1:0]     rs2,
  output logic                      rs1_pending,
  output logic                      rs2_pending,
  output logic                      reg_write,
  output logic [REG_ADDR_W-1:0]     wr_rd,
  output logic [XLEN-1:0]           wr_data,
  output logic [$clog2(LQ_DEPTH):0] lq_count
`ifdef WB_BYPASS_EN
  ,
  output logic                      fwd_rs1_hit,
  output logic                      fwd_rs2_hit,
  output logic [XLEN-1:0]           fwd_rs1_data,
  output logic [XLEN-1:0]           fwd_rs2_data
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  wb_req_t           lq_head;
  logic              lq_full;
  logic              lq_empty;
  logic              lq_push;
  logic              lq_pop;
  logic              alu_sel;
  logic [PEND_W-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;

  // Readiness depends only on registered occupancy, so a pop never frees a slot
  // for a push in the same cycle.
  assign mem_ready = !lq_full;
  assign lq_push   = mem_valid && mem_ready;
  assign alu_sel   = alu_valid && (alu_rd != REG_ZERO);
  assign lq_pop    = !alu_sel && !lq_empty;

  wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk       (clk),
    .reset     (reset),
    .push      (lq_push),
    .push_data ('{rd: mem_rd, data: mem_data}),
    .pop       (lq_pop),
    .head      (lq_head),
    .full      (lq_full),
    .empty     (lq_empty),
    .count     (lq_count)
  );

  // NOTE: registered state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_write <= 1'b0;
      wr_rd     <= '0;
      wr_data   <= '0;
    end else begin
      reg_write <= 1'b0;
      if (alu_sel) begin
        reg_write <= 1'b1;
        wr_rd     <= alu_rd;
        wr_data   <= alu_data;
      end else if (lq_pop && (lq_head.rd != REG_ZERO)) begin
        reg_write <= 1'b1;
        wr_rd     <= lq_head.rd;
        wr_data   <= lq_head.data;
      end
    end
  end

  assign issue_load_ready = (cnt[issue_load_rd] != PEND_MAX);
  assign rs1_pending      = (cnt[rs1] != '0);
  assign rs2_pending      = (cnt[rs2] != '0);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (issue_load_valid && issue_load_ready && (issue_load_rd != REG_ZERO))
      inc_vec[issue_load_rd] = 1'b1;
    if (lq_pop && (lq_head.rd != REG_ZERO) && (cnt[lq_head.rd] != '0))
      dec_vec[lq_head.rd] = 1'b1;
  end

  // Entry 0 is only ever written by reset, which keeps it constant zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (inc_vec[r] && !dec_vec[r])      cnt[r] <= cnt[r] + PEND_W'(1);
        else if (dec_vec[r] && !inc_vec[r]) cnt[r] <= cnt[r] - PEND_W'(1);
      end
    end
  end

  // A load returning to a register with nothing outstanding breaks the protocol.
  a_no_underflow : assert property (@(posedge clk) disable iff (reset)
    (lq_pop && (lq_head.rd != REG_ZERO)) |-> (cnt[lq_head.rd] != '0));

`ifdef WB_BYPASS_EN
  assign fwd_rs1_hit  = reg_write && (wr_rd == rs1) && (rs1 != REG_ZERO);
  assign fwd_rs2_hit  = reg_write && (wr_rd == rs2) && (rs2 != REG_ZERO);
  assign fwd_rs1_data = wr_data;
  assign fwd_rs2_data = wr_data;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Bench for regfile_wb_ctrl: directed scenarios plus a random stream, all
// checked against a queue/array reference model of the write-back rules.
module tb_regfile_wb_ctrl;
  import regfile_pkg::*;

  localparam int LQ_DEPTH = 4;
  localparam int PEND_W   = 3;
  localparam int PMAX     = (1 << PEND_W) - 1;
  localparam int CW       = $clog2(LQ_DEPTH) + 1;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  mem_valid;
  logic                  mem_ready;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  issue_load_valid;
  logic [REG_ADDR_W-1:0] issue_load_rd;
  logic                  issue_load_ready;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic                  rs1_pending;
  logic                  rs2_pending;
  logic                  reg_write;
  logic [REG_ADDR_W-1:0] wr_rd;
  logic [XLEN-1:0]       wr_data;
  logic [CW-1:0]         lq_count;
`ifdef WB_BYPASS_EN
  logic                  fwd_rs1_hit;
  logic                  fwd_rs2_hit;
  logic [XLEN-1:0]       fwd_rs1_data;
  logic [XLEN-1:0]       fwd_rs2_data;
`endif

  always #5 clk = ~clk;

  regfile_wb_ctrl #(.LQ_DEPTH(LQ_DEPTH), .PEND_W(PEND_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_data         (alu_data),
    .mem_valid        (mem_valid),
    .mem_ready        (mem_ready),
    .mem_rd           (mem_rd),
    .mem_data         (mem_data),
    .issue_load_valid (issue_load_valid),
    .issue_load_rd    (issue_load_rd),
    .issue_load_ready (issue_load_ready),
    .rs1              (rs1),
    .rs2              (rs2),
    .rs1_pending      (rs1_pending),
    .rs2_pending      (rs2_pending),
    .reg_write        (reg_write),
    .wr_rd            (wr_rd),
    .wr_data          (wr_data),
    .lq_count         (lq_count)
`ifdef WB_BYPASS_EN
    ,
    .fwd_rs1_hit      (fwd_rs1_hit),
    .fwd_rs2_hit      (fwd_rs2_hit),
    .fwd_rs1_data     (fwd_rs1_data),
    .fwd_rs2_data     (fwd_rs2_data)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: load queue contents, outstanding counts, write port.
  wb_req_t               q[$];
  int                    pend [NUM_REGS];
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_rd;
  logic [XLEN-1:0]       m_data;
  logic [REG_ADDR_W-1:0] inflight[$];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = '0; alu_data = '0;
    mem_valid = 0; mem_rd = '0; mem_data = '0;
    issue_load_valid = 0; issue_load_rd = '0;
  endtask

  task automatic model_reset();
    q.delete();
    inflight.delete();
    for (int r = 0; r < NUM_REGS; r++) pend[r] = 0;
    m_we = 0; m_rd = '0; m_data = '0;
  endtask

  // Called one time unit after a rising edge with inputs already driven.
  task automatic cycle();
    wb_req_t e;
    bit      ilr, alu_sel, acc;
    #1;
    check("mem_ready", mem_ready, q.size() < LQ_DEPTH);
    check("lq_count", lq_count, q.size());
    ilr = (pend[issue_load_rd] != PMAX);
    check("issue_load_ready", issue_load_ready, ilr);
    check("rs1_pending", rs1_pending, pend[rs1] != 0);
    check("rs2_pending", rs2_pending, pend[rs2] != 0);
`ifdef WB_BYPASS_EN
    check("fwd_rs1_hit", fwd_rs1_hit, m_we && m_rd == rs1 && rs1 != 0);
    check("fwd_rs2_hit", fwd_rs2_hit, m_we && m_rd == rs2 && rs2 != 0);
    check("fwd_rs1_data", fwd_rs1_data, m_data);
`endif
    alu_sel = alu_valid && alu_rd != 0;
    acc     = mem_valid && q.size() < LQ_DEPTH;
    m_we    = 0;
    if (alu_sel) begin
      m_we = 1; m_rd = alu_rd; m_data = alu_data;
    end else if (q.size() != 0) begin
      e = q.pop_front();
      if (e.rd != 0) begin
        m_we = 1; m_rd = e.rd; m_data = e.data;
        if (pend[e.rd] > 0) pend[e.rd]--;
      end
    end
    if (issue_load_valid && ilr) begin
      if (issue_load_rd != 0) pend[issue_load_rd]++;
      inflight.push_back(issue_load_rd);
    end
    if (acc) begin
      e.rd = mem_rd; e.data = mem_data;
      q.push_back(e);
      if (inflight.size() != 0) void'(inflight.pop_front());
    end
    @(posedge clk);
    #1;
    check("reg_write", reg_write, m_we);
    check("wr_rd", wr_rd, m_rd);
    check("wr_data", wr_data, m_data);
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    model_reset();
    check("rst_reg_write", reg_write, 0);
    check("rst_wr_rd", wr_rd, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_lq_count", lq_count, 0);
    check("rst_mem_ready", mem_ready, 1);
    for (int r = 0; r < NUM_REGS; r++) begin
      rs1 = REG_ADDR_W'(r);
      #1;
      check("rst_rs1_pending", rs1_pending, 0);
    end
    idle();
    rs1 = '0; rs2 = '0;
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0;
    do_reset();

    // ALU only, then ALU to x0.
    alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
    cycle();
    check("alu_wr_rd", wr_rd, 5);
    check("alu_wr_data", wr_data, 64'h1234);
    alu_rd = 0; alu_data = 64'hdead;
    cycle();
    check("alu_x0_reg_write", reg_write, 0);
    idle();

`ifdef WB_BYPASS_EN
    alu_valid = 1; alu_rd = 12; alu_data = 64'hc0ffee;
    cycle();
    idle();
    rs2 = 12;
    #1;
    check("byp_hit", fwd_rs2_hit, 1);
    check("byp_data", fwd_rs2_data, 64'hc0ffee);
    rs2 = 0;
    #1;
    check("byp_x0", fwd_rs2_hit, 0);
    cycle();
`endif

    // Priority: a queued load waits behind three ALU writes.
    issue_load_valid = 1; issue_load_rd = 7;
    cycle();
    idle();
    mem_valid = 1; mem_rd = 7; mem_data = 64'hAA;
    alu_valid = 1; alu_rd = 1; alu_data = 64'h11;
    cycle();
    mem_valid = 0;
    alu_rd = 2; alu_data = 64'h22;
    cycle();
    check("prio_lq_count", lq_count, 1);
    alu_rd = 3; alu_data = 64'h33;
    cycle();
    idle();
    cycle();
    check("prio_load_rd", wr_rd, 7);
    check("prio_load_data", wr_data, 64'hAA);
    cycle();
    check("prio_lq_empty", lq_count, 0);

    // Full queue: fifth return stalls until ALU traffic stops.
    for (int i = 0; i < 5; i++) begin
      issue_load_valid = 1; issue_load_rd = REG_ADDR_W'(10 + i);
      cycle();
    end
    idle();
    alu_valid = 1; alu_rd = 20;
    for (int i = 0; i < 7; i++) begin
      alu_data = 64'(i);
      mem_valid = 1; mem_rd = REG_ADDR_W'(10 + (i < 4 ? i : 4));
      mem_data = 64'h100 + 64'(i < 4 ? i : 4);
      cycle();
    end
    check("full_mem_ready", mem_ready, 0);
    alu_valid = 0;
    cycle();
    cycle();
    mem_valid = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("full_drained", lq_count, 0);

    // Scoreboard: two loads to x9, then a pop overlapping a new issue.
    rs1 = 9;
    issue_load_valid = 1; issue_load_rd = 9;
    cycle();
    cycle();
    idle();
    mem_valid = 1; mem_rd = 9; mem_data = 64'h901;
    cycle();
    idle();
    cycle();
    check("sb_after_first", rs1_pending, 1);
    mem_valid = 1; mem_rd = 9; mem_data = 64'h902;
    cycle();
    idle();
    issue_load_valid = 1; issue_load_rd = 9;
    cycle();
    idle();
    check("sb_issue_pop", rs1_pending, 1);
    mem_valid = 1; mem_rd = 9; mem_data = 64'h903;
    cycle();
    idle();
    cycle();
    check("sb_cleared", rs1_pending, 0);

    // Reset mid-stream with three loads queued.
    for (int i = 0; i < 3; i++) begin
      issue_load_valid = 1; issue_load_rd = REG_ADDR_W'(4 + i);
      cycle();
    end
    idle();
    alu_valid = 1; alu_rd = 30;
    for (int i = 0; i < 3; i++) begin
      mem_valid = 1; mem_rd = REG_ADDR_W'(4 + i); mem_data = 64'(i);
      cycle();
    end
    check("mid_lq_count", lq_count, 3);
    do_reset();

    // Random traffic; returns always follow an earlier accepted issue.
    for (int n = 0; n < 600; n++) begin
      alu_valid        = ($urandom_range(0, 2) == 0);
      alu_rd           = REG_ADDR_W'($urandom_range(0, 31));
      alu_data         = {$urandom, $urandom};
      issue_load_valid = ($urandom_range(0, 4) < 3);
      issue_load_rd    = REG_ADDR_W'($urandom_range(0, 3));
      mem_valid        = (inflight.size() != 0) && ($urandom_range(0, 1) == 0);
      mem_rd           = (inflight.size() != 0) ? inflight[0] : '0;
      mem_data         = {$urandom, $urandom};
      rs1              = REG_ADDR_W'($urandom_range(0, 7));
      rs2              = REG_ADDR_W'($urandom_range(0, 7));
      cycle();
    end
    idle();
    for (int n = 0; n < 200; n++) begin
      mem_valid = (inflight.size() != 0);
      mem_rd    = (inflight.size() != 0) ? inflight[0] : '0;
      mem_data  = {$urandom, $urandom};
      rs1       = REG_ADDR_W'(n % 4);
      rs2       = REG_ADDR_W'((n + 1) % 4);
      cycle();
    end
    check("rand_drained", lq_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
